dmem_responder: RTL and testbench
=================================

DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 Parameter DATA_W, default 32: data word width in bits.
REQ-002 Parameter DM_ADDRESS, default 9: byte-address width; the array holds 2^(DM_ADDRESS-2) = 128 words.
REQ-003 Parameter WAIT_CYCLES, default 1, legal range 0..15: extra access cycles inserted before each response.
REQ-004 The ports SHALL be as follows:
- clk  input  1  sole clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- req_valid  input  1  initiator presents a request.
- req_ready  output  1  responder can accept a request.
- req_we  input  1  1 = store, 0 = load.
- req_addr  input  DM_ADDRESS  byte address, little-endian.
- req_wdata  input  DATA_W  store data, right-aligned.
- req_funct3  input  3  RISC-V access size/sign code.
- rsp_valid  output  1  response available.
- rsp_ready  input  1  initiator accepts the response.
- rsp_rdata  output  DATA_W  load result; 0 for stores and errors.
- rsp_err  output  1  request rejected; no side effect.
- busy  output  1  state is not IDLE.

Function
REQ-005 The FSM SHALL have exactly three states: IDLE, ACCESS and RESP.
REQ-006 req_ready SHALL be 1 only in IDLE; it SHALL never be asserted combinationally from req_valid.
REQ-007 On an edge with req_valid=1 in IDLE, the block SHALL capture we, addr, wdata and funct3, load the wait counter with WAIT_CYCLES, and enter ACCESS.
REQ-008 In ACCESS, while the counter is nonzero, each edge SHALL decrement it; the edge at which the counter is 0 SHALL perform the access, register rsp_rdata/rsp_err, and enter RESP.
REQ-009 Response timing: a request accepted at edge E0 SHALL have rsp_valid=1 after edge E0+WAIT_CYCLES+1.
REQ-010 In RESP, rsp_valid, rsp_rdata and rsp_err SHALL hold stable until an edge with rsp_ready=1, which SHALL return the FSM to IDLE.
REQ-011 A new request SHALL be accepted no earlier than the edge after the RESP exit, so back-to-back throughput is one request per WAIT_CYCLES+3 cycles.
REQ-012 Addressing: the word index SHALL be addr[DM_ADDRESS-1:2] and the byte lane addr[1:0]; the index wraps naturally at the array end.
REQ-013 Loads:
- funct3 000 (LB) and 001 (LH): sign-extended.
- funct3 100 (LBU) and 101 (LHU): zero-extended.
- funct3 010 (LW): full word.
- The halfword lane SHALL be selected by addr[1].
REQ-014 Stores:
- funct3 000 (SB): write only the addressed byte lane.
- funct3 001 (SH): write only the addressed halfword.
- funct3 010 (SW): write all four lanes.
- Other lanes SHALL be unchanged.
REQ-015 Any other funct3 (loads: 011, 110, 111; stores: 011 and above) SHALL give rsp_err=1 and rsp_rdata=0, with no array write.
REQ-016 A store SHALL commit exactly once, at the REQ-008 edge; a store response SHALL carry rsp_rdata=0.
REQ-017 Input changes while not in IDLE SHALL have no effect.

Reset
REQ-018 Asserting reset SHALL immediately, without a clock, force:
- state to IDLE and the counter to 0;
- rsp_valid=0, rsp_err=0, rsp_rdata=0, busy=0, req_ready=0 while reset is held.
REQ-019 req_ready SHALL be 1 on the first cycle after reset deasserts.
REQ-020 Reset in ACCESS before the commit edge SHALL discard the store; array contents SHALL never be cleared by reset.

Configuration
REQ-021 With macro DMEM_MISALIGN_CHK_EN defined, the following SHALL give rsp_err=1, rsp_rdata=0 and no write:
- halfword accesses with addr[0]=1;
- word accesses with addr[1:0]≠0.
REQ-022 Without DMEM_MISALIGN_CHK_EN:
- halfword accesses SHALL ignore addr[0];
- word accesses SHALL ignore addr[1:0];
- rsp_err SHALL flag only illegal funct3.

Verification
REQ-023 Word round trip: SW addr 0x010 data 0xDEADBEEF, then LW 0x010 -> rsp_rdata=0xDEADBEEF, rsp_err=0, rsp_valid rising 2 edges after acceptance (WAIT_CYCLES=1).
REQ-024 Lane and sign handling: SW 0x020 0x11223344, SB 0x021 0x000000F0, then:
- LW 0x020 -> 0x1122F044.
- LB 0x021 -> 0xFFFFFFF0.
- LBU 0x021 -> 0x000000F0.
- LH 0x022 -> 0x00001122.
REQ-025 Backpressure: hold rsp_ready=0 for 5 cycles in RESP -> rsp_valid and rsp_rdata stable and req_ready=0 throughout; one edge with rsp_ready=1 -> IDLE, req_ready=1 on the next cycle.
REQ-026 Illegal funct3: store with funct3 011 to 0x030 -> rsp_err=1; a following LW 0x030 returns the prior contents unchanged.
REQ-027 Misalignment: LW 0x041 -> rsp_err=1 with DMEM_MISALIGN_CHK_EN; without it -> word at 0x040 and rsp_err=0.
REQ-028 Reset mid-access: WAIT_CYCLES=3, SW 0x050 0xCAFEF00D, reset pulsed one cycle after acceptance -> outputs cleared asynchronously, busy=0; a subsequent LW 0x050 returns the pre-store value.

Source files
------------

// File: rtl/dmem_responder.sv
// dmem_responder: single-port word-organised data memory behind a
// valid/ready request/response handshake, with RISC-V load/store sizing.
//
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   req_valid / req_ready      request handshake (ready only in IDLE)
//   req_we, req_addr,          store flag, byte address,
//   req_wdata, req_funct3      right-aligned store data, size/sign code
//   rsp_valid / rsp_ready      response handshake (held until accepted)
//   rsp_rdata, rsp_err         load result (0 for stores/errors), reject flag
//   busy                       FSM is not IDLE
//
// Build option: define DMEM_MISALIGN_CHK_EN to reject misaligned halfword
// and word accesses; by default low address bits are ignored for them.
module dmem_responder #(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned DM_ADDRESS  = 9,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [DM_ADDRESS-1:0] req_addr,
  input  logic [DATA_W-1:0]     req_wdata,
  input  logic [2:0]            req_funct3,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_W-1:0]     rsp_rdata,
  output logic                  rsp_err,
  output logic                  busy
);

  localparam int unsigned WORDS = 1 << (DM_ADDRESS - 2);
  localparam int unsigned CNT_W = 4;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_RESP   = 2'd2;

  logic [1:0]            state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  we_q, we_d;
  logic [DM_ADDRESS-1:0] addr_q, addr_d;
  logic [DATA_W-1:0]     wdata_q, wdata_d;
  logic [2:0]            funct3_q, funct3_d;
  logic [DATA_W-1:0]     rdata_q, rdata_d;
  logic                  err_q, err_d;

  logic [DATA_W-1:0]     mem [WORDS];

  logic [DATA_W-1:0]     word_c;
  logic [4:0]            byte_sh_c;
  logic [4:0]            half_sh_c;
  logic [7:0]            byte_c;
  logic [15:0]           half_c;
  logic                  err_c;
  logic [DATA_W-1:0]     load_c;
  logic [DATA_W-1:0]     smask_c;
  logic [DATA_W-1:0]     sdata_c;
  logic                  commit_c;
  logic                  mem_we_c;

  // Decode of the captured request against the addressed word.
  always_comb begin
    word_c    = mem[addr_q[DM_ADDRESS-1:2]];
    byte_sh_c = {addr_q[1:0], 3'b000};
    half_sh_c = {addr_q[1], 4'b0000};
    byte_c    = 8'(word_c >> byte_sh_c);
    half_c    = 16'(word_c >> half_sh_c);

    err_c = 1'b0;
    if (we_q) begin
      if (funct3_q != 3'b000 && funct3_q != 3'b001 && funct3_q != 3'b010)
        err_c = 1'b1;
    end else begin
      if (funct3_q == 3'b011 || funct3_q == 3'b110 || funct3_q == 3'b111)
        err_c = 1'b1;
    end
`ifdef DMEM_MISALIGN_CHK_EN
    if (funct3_q[1:0] == 2'b01 && addr_q[0])
      err_c = 1'b1;
    if (funct3_q[1:0] == 2'b10 && addr_q[1:0] != 2'b00)
      err_c = 1'b1;
`endif

    case (funct3_q)
      3'b000:  load_c = {{(DATA_W-8){byte_c[7]}}, byte_c};
      3'b100:  load_c = {{(DATA_W-8){1'b0}}, byte_c};
      3'b001:  load_c = {{(DATA_W-16){half_c[15]}}, half_c};
      3'b101:  load_c = {{(DATA_W-16){1'b0}}, half_c};
      default: load_c = word_c;
    endcase

    // Store lane mask and lane-aligned data; SW writes the whole word.
    case (funct3_q)
      3'b000: begin
        smask_c = DATA_W'(8'hFF) << byte_sh_c;
        sdata_c = DATA_W'(wdata_q[7:0]) << byte_sh_c;
      end
      3'b001: begin
        smask_c = DATA_W'(16'hFFFF) << half_sh_c;
        sdata_c = DATA_W'(wdata_q[15:0]) << half_sh_c;
      end
      default: begin
        smask_c = '1;
        sdata_c = wdata_q;
      end
    endcase

    commit_c = (state_q == S_ACCESS) && (cnt_q == '0);
    mem_we_c = commit_c && we_q && !err_c && !reset;
  end

  // Next-state and captured-request logic.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    funct3_d = funct3_q;
    rdata_d  = rdata_q;
    err_d    = err_q;

    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          we_d     = req_we;
          addr_d   = req_addr;
          wdata_d  = req_wdata;
          funct3_d = req_funct3;
          cnt_d    = CNT_W'(WAIT_CYCLES);
          state_d  = S_ACCESS;
        end
      end
      S_ACCESS: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          err_d   = err_c;
          rdata_d = (we_q || err_c) ? '0 : load_c;
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        if (rsp_ready)
          state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control and response registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      funct3_q <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      funct3_q <= funct3_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

  // Storage array: contents survive reset.
  always_ff @(posedge clk) begin
    if (mem_we_c)
      mem[addr_q[DM_ADDRESS-1:2]] <= (word_c & ~smask_c) | (sdata_c & smask_c);
  end

  assign req_ready = (state_q == S_IDLE) && !reset;
  assign rsp_valid = (state_q == S_RESP);
  assign busy      = (state_q != S_IDLE);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: directed scenarios plus random traffic checked
// against a byte-addressed reference memory.
module tb_dmem_responder;

  localparam int unsigned WAIT = 1;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [8:0]  req_addr;
  logic [31:0] req_wdata;
  logic [2:0]  req_funct3;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        busy;

  int total = 0;
  int bad   = 0;

  logic [7:0] mb [512];

  dmem_responder #(
    .DATA_W     (32),
    .DM_ADDRESS (9),
    .WAIT_CYCLES(WAIT)
  ) u_dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_funct3(req_funct3),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: little-endian byte memory, RISC-V sizing rules.
  function automatic void mdl(input logic we, input logic [8:0] a, input logic [31:0] wd,
                              input logic [2:0] f3, output logic [31:0] rd, output logic er);
    int sz;
    int base;
    logic [31:0] v;
    rd = '0;
    er = 1'b0;
    v  = '0;
    sz = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : (f3[1:0] == 2'd2) ? 4 : 0;
    if (sz == 0) er = 1'b1;
    if (we && f3[2]) er = 1'b1;
    if (!we && f3 == 3'b110) er = 1'b1;
`ifdef DMEM_MISALIGN_CHK_EN
    if (sz == 2 && a[0]) er = 1'b1;
    if (sz == 4 && a[1:0] != 2'b00) er = 1'b1;
`endif
    if (!er) begin
      base = int'(a) - (int'(a) % sz);
      for (int b = 0; b < sz; b++) begin
        if (we) mb[base + b] = wd[8*b +: 8];
        else    v[8*b +: 8]  = mb[base + b];
      end
      if (!we) begin
        if (sz == 1)      rd = f3[2] ? {24'h0, v[7:0]}  : {{24{v[7]}}, v[7:0]};
        else if (sz == 2) rd = f3[2] ? {16'h0, v[15:0]} : {{16{v[15]}}, v[15:0]};
        else              rd = v;
      end
    end
  endfunction

  // One complete transaction; returns what the DUT responded.
  task automatic xact(input logic we, input logic [8:0] a, input logic [31:0] wd,
                      input logic [2:0] f3, input int stall,
                      output logic [31:0] rd_o, output logic er_o);
    int n;
    logic [31:0] exp_rd;
    logic        exp_er;
    chk("req_ready_idle", 32'(req_ready), 32'd1);
    req_valid  = 1'b1;
    req_we     = we;
    req_addr   = a;
    req_wdata  = wd;
    req_funct3 = f3;
    @(posedge clk); #1;
    // Scramble inputs while busy; they must be ignored.
    req_valid  = 1'($urandom);
    req_we     = 1'($urandom);
    req_addr   = 9'($urandom);
    req_wdata  = $urandom;
    req_funct3 = 3'($urandom);
    chk("busy_after_accept", 32'(busy), 32'd1);
    n = 0;
    while (!rsp_valid && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk("rsp_latency", 32'(n), 32'(WAIT + 1));
    mdl(we, a, wd, f3, exp_rd, exp_er);
    rd_o = rsp_rdata;
    er_o = rsp_err;
    chk("rsp_rdata", rsp_rdata, exp_rd);
    chk("rsp_err", 32'(rsp_err), 32'(exp_er));
    rsp_ready = 1'b0;
    for (int i = 0; i < stall; i++) begin
      @(posedge clk); #1;
      chk("hold_valid", 32'(rsp_valid), 32'd1);
      chk("hold_rdata", rsp_rdata, rd_o);
      chk("hold_err", 32'(rsp_err), 32'(er_o));
      chk("hold_ready_low", 32'(req_ready), 32'd0);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    chk("exit_valid_low", 32'(rsp_valid), 32'd0);
    chk("exit_busy_low", 32'(busy), 32'd0);
  endtask

  initial begin
    logic [31:0] rd;
    logic        er;
    logic [31:0] old50;
    int          n;

    reset      = 1'b1;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_addr   = '0;
    req_wdata  = '0;
    req_funct3 = '0;
    rsp_ready  = 1'b0;
    for (int i = 0; i < 512; i++) mb[i] = 8'h00;

    // Reset state
    #12;
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_err", 32'(rsp_err), 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    chk("post_rst_ready", 32'(req_ready), 32'd1);

    // Give every word a known nonzero value.
    for (int i = 0; i < 128; i++)
      xact(1'b1, 9'(i * 4), $urandom | 32'h1, 3'b010, 0, rd, er);

    // Word round trip
    xact(1'b1, 9'h010, 32'hDEADBEEF, 3'b010, 0, rd, er);
    chk("sw_rdata_zero", rd, 32'h0);
    xact(1'b0, 9'h010, 32'h0, 3'b010, 0, rd, er);
    chk("lw_roundtrip", rd, 32'hDEADBEEF);
    chk("lw_roundtrip_err", 32'(er), 32'd0);

    // Lanes and sign handling
    xact(1'b1, 9'h020, 32'h11223344, 3'b010, 0, rd, er);
    xact(1'b1, 9'h021, 32'h000000F0, 3'b000, 0, rd, er);
    xact(1'b0, 9'h020, 32'h0, 3'b010, 0, rd, er);
    chk("lw_after_sb", rd, 32'h1122F044);
    xact(1'b0, 9'h021, 32'h0, 3'b000, 0, rd, er);
    chk("lb_sign", rd, 32'hFFFFFFF0);
    xact(1'b0, 9'h021, 32'h0, 3'b100, 0, rd, er);
    chk("lbu_zero", rd, 32'h000000F0);
    xact(1'b0, 9'h022, 32'h0, 3'b001, 0, rd, er);
    chk("lh_upper", rd, 32'h00001122);

    // Backpressure for five cycles
    xact(1'b0, 9'h020, 32'h0, 3'b010, 5, rd, er);
    chk("bp_rdata", rd, 32'h1122F044);
    #1;
    chk("bp_ready_after", 32'(req_ready), 32'd1);

    // Illegal store size leaves memory untouched
    xact(1'b1, 9'h030, 32'h55AA55AA, 3'b011, 0, rd, er);
    chk("illegal_err", 32'(er), 32'd1);
    chk("illegal_rdata", rd, 32'h0);
    xact(1'b0, 9'h030, 32'h0, 3'b010, 0, rd, er);
    chk("illegal_no_write", 32'(er), 32'd0);

    // Misaligned word load
    xact(1'b0, 9'h041, 32'h0, 3'b010, 0, rd, er);
`ifdef DMEM_MISALIGN_CHK_EN
    chk("misalign_err", 32'(er), 32'd1);
`else
    chk("misalign_err", 32'(er), 32'd0);
`endif

    // Reset during ACCESS discards a pending store.
    xact(1'b0, 9'h050, 32'h0, 3'b010, 0, rd, er);
    old50 = rd;
    chk("pre_reset_rdata_nonzero", 32'(rd != 32'h0), 32'd1);
    req_valid  = 1'b1;
    req_we     = 1'b1;
    req_addr   = 9'h050;
    req_wdata  = 32'hCAFEF00D;
    req_funct3 = 3'b010;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_valid", 32'(rsp_valid), 32'd0);
    chk("midrst_rdata", rsp_rdata, 32'h0);
    chk("midrst_err", 32'(rsp_err), 32'd0);
    chk("midrst_ready", 32'(req_ready), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    chk("midrst_ready_after", 32'(req_ready), 32'd1);
    xact(1'b0, 9'h050, 32'h0, 3'b010, 0, rd, er);
    chk("midrst_store_discarded", rd, old50);

    // Random traffic
    for (int k = 0; k < 300; k++)
      xact(1'($urandom), 9'($urandom), $urandom, 3'($urandom), int'($urandom_range(0, 3)), rd, er);

    // Unbounded wait guard: the FSM must be idle now.
    n = 0;
    while (busy && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("final_idle", 32'(busy), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
